keypad_scan_ctrl: RTL

//  Scan/debounce controller for the 3x4 matrix keypad peripheral.
//  - Drives the four row lines one-hot and samples the three column lines.
//  - Debounces whole scan frames and queues debounced key codes in a small FIFO.
//  - Raises a CPU interrupt with an acknowledge handshake.

---
 rtl/keypad_scan_if.sv | 24 ++
 rtl/keypad_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad controller bus: pin-side row/column lines plus CPU-side
// key FIFO read port, interrupt request/acknowledge and overflow flag.
interface keypad_scan_if;
   logic [2:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_rd;
   logic       intr;
   logic       int_ack;
   logic       ovf;

   // controller side
   modport master (
      input  col, key_rd, int_ack,
      output row, key_code, key_valid, intr, ovf
   );

   // pins + CPU side
   modport slave (
      output col, key_rd, int_ack,
      input  row, key_code, key_valid, intr, ovf
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 matrix keypad scan/debounce controller with key-code FIFO and
// CPU interrupt. Rows are driven one-hot from an internal scan counter,
// whole frames are debounced, and one code is queued per press.
// Optional build macro KEYPAD_INT_PULSE_EN: interrupt becomes a 1-cycle
// pulse per accepted push and INT_ACK is ignored; otherwise a level
// request cleared by INT_ACK.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   keypad_scan_if.master kp
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_CAND, S_HELD} state_t;

   // ---------------- scan timing ----------------
   logic [SW-1:0] scan_cnt;
   logic [1:0]    row_idx;
   logic          sample_en;
   logic          frame_end;

   assign sample_en = (scan_cnt == SW'(SCAN_DIV - 1));
   assign frame_end = sample_en && (row_idx == 2'd3);
   assign kp.row    = 4'b0001 << row_idx;

   // Hold each row SCAN_DIV cycles, then rotate to the next row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         row_idx  <= 2'd0;
      end else if (sample_en) begin
         scan_cnt <= '0;
         row_idx  <= row_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // ---------------- frame key ----------------
   logic       cur_hit;
   logic [1:0] col_sel;
   logic [3:0] cur_code;
   logic       found;
   logic [3:0] found_code;
   logic       frame_hit;
   logic [3:0] frame_code;

   // Code of the lowest asserted column on the row being sampled now.
   always_comb begin
      cur_hit  = |kp.col;
      col_sel  = 2'd2;
      if (kp.col[0])      col_sel = 2'd0;
      else if (kp.col[1]) col_sel = 2'd1;
      cur_code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_sel} + 4'd1;
      if (row_idx == 2'd3) begin
         case (col_sel)
            2'd0:    cur_code = 4'd10;
            2'd1:    cur_code = 4'd0;
            default: cur_code = 4'd11;
         endcase
      end
   end

   // An earlier row's hit has priority over the current row's sample.
   assign frame_hit  = found | cur_hit;
   assign frame_code = found ? found_code : cur_code;

   // Remember the first hit of the frame; start fresh after row 3.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         found      <= 1'b0;
         found_code <= 4'd0;
      end else if (sample_en) begin
         if (row_idx == 2'd3) begin
            found <= 1'b0;
         end else if (!found && cur_hit) begin
            found      <= 1'b1;
            found_code <= cur_code;
         end
      end
   end

   // ---------------- debounce FSM ----------------
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [3:0]    cand, cand_n;
   logic          push_q, push_n;
   logic [3:0]    push_code, push_code_n;

   assign cnt_inc = cnt + 1'b1;

   // Debounce state, run counter and registered push request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cand      <= 4'd0;
         push_q    <= 1'b0;
         push_code <= 4'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         push_q    <= push_n;
         push_code <= push_code_n;
      end
   end

   // Per-frame debounce decision; cnt counts matching frames in CAND
   // and consecutive empty frames in HELD.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      push_n      = 1'b0;
      push_code_n = push_code;
      if (frame_end) begin
         case (state)
            S_IDLE: begin
               if (frame_hit) begin
                  cand_n = frame_code;
                  if (DEBOUNCE_CNT == 1) begin
                     push_n      = 1'b1;
                     push_code_n = frame_code;
                     state_n     = S_HELD;
                     cnt_n       = '0;
                  end else begin
                     state_n = S_CAND;
                     cnt_n   = CW'(1);
                  end
               end
            end
            S_CAND: begin
               if (!frame_hit) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (frame_code == cand) begin
                  if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                     push_n      = 1'b1;
                     push_code_n = cand;
                     state_n     = S_HELD;
                     cnt_n       = '0;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  cand_n = frame_code;
                  cnt_n  = CW'(1);
               end
            end
            S_HELD: begin
               if (frame_hit) begin
                  cnt_n = '0;
               end else if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // ---------------- key FIFO ----------------
   logic [3:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] fill;
   logic        empty, full, pop, push_ok;

   assign fill    = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (fill == (AW+1)'(FIFO_DEPTH));
   assign pop     = kp.key_rd & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push_q & (~full | pop);

   assign kp.key_valid = ~empty;
   assign kp.key_code  = empty ? 4'd0 : mem[rd_ptr[AW-1:0]];

   // Storage needs no reset; the code output is gated by empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_code;
   end

   // Pointers carry one extra wrap bit to tell full from empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky overflow: set on a dropped code, cleared by a real read.
   always_ff @(posedge clk) begin
      if (!rst_n)                 kp.ovf <= 1'b0;
      else if (push_q && !push_ok) kp.ovf <= 1'b1;
      else if (pop)               kp.ovf <= 1'b0;
   end

   // ---------------- interrupt ----------------
`ifdef KEYPAD_INT_PULSE_EN
   logic unused_int_ack;
   assign unused_int_ack = kp.int_ack;

   // One-cycle pulse after every accepted push.
   always_ff @(posedge clk) begin
      if (!rst_n) kp.intr <= 1'b0;
      else        kp.intr <= push_ok;
   end
`else
   // Level request: set by any push, cleared by acknowledge; push wins.
   always_ff @(posedge clk) begin
      if (!rst_n)          kp.intr <= 1'b0;
      else if (push_q)     kp.intr <= 1'b1;
      else if (kp.int_ack) kp.intr <= 1'b0;
   end
`endif

endmodule
